// File: rtl/spi_flash_reader.sv
// spi_flash_reader
// ----------------
// SPI mode-0 master that performs a single-word serial-flash READ (03h).
// A bus request carrying a 24-bit byte address is turned into a 64-bit frame:
// 8 command bits, 24 address bits and 32 data bits. During the data bits the
// reply on miso is collected and returned as one 32-bit word.
//
// Ports:
//   clock       system clock; sck is derived from it by a divider
//   reset       asynchronous, active-high reset
//   req_valid   read request valid
//   req_ready   request accepted when req_valid && req_ready
//   req_addr    24-bit flash byte address, sent MSB first
//   resp_valid  read data valid
//   resp_ready  response consumed when resp_valid && resp_ready
//   resp_data   received word; the first data bit on miso lands in bit 31
//   sck         SPI clock, idles low
//   ss          SPI chip select, active-low
//   mosi        serial data to the flash
//   miso        serial data from the flash
//
// Parameter CLK_DIV: system-clock cycles per sck half-period (>= 1).

module spi_flash_reader #(
  parameter int CLK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("spi_flash_reader: CLK_DIV must be at least 1");
    end
  endgenerate

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] tx_reg, tx_next;
  logic [31:0] rx_reg, rx_next;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic        sck_reg, sck_next;
  logic        ss_reg, ss_next;
  logic        req_ready_reg, req_ready_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [31:0] resp_data_reg, resp_data_next;

  // Every output comes straight from a flop. mosi is the TX MSB, which is
  // all-zero outside a frame because the register is fully shifted out by
  // the end of bit 63 (or cleared by reset).
  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign sck        = sck_reg;
  assign ss         = ss_reg;
  assign mosi       = tx_reg[63];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      tx_reg         <= '0;
      rx_reg         <= '0;
      bit_cnt_reg    <= '0;
      div_reg        <= '0;
      sck_reg        <= 1'b0;
      ss_reg         <= 1'b1;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      tx_reg         <= tx_next;
      rx_reg         <= rx_next;
      bit_cnt_reg    <= bit_cnt_next;
      div_reg        <= div_next;
      sck_reg        <= sck_next;
      ss_reg         <= ss_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    tx_next         = tx_reg;
    rx_next         = rx_reg;
    bit_cnt_next    = bit_cnt_reg;
    div_next        = div_reg;
    sck_next        = sck_reg;
    ss_next         = ss_reg;
    req_ready_next  = req_ready_reg;
    resp_valid_next = resp_valid_reg;
    resp_data_next  = resp_data_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          tx_next        = {8'h03, req_addr, 32'h0};
          rx_next        = '0;
          bit_cnt_next   = '0;
          div_next       = '0;
          sck_next       = 1'b0;
          ss_next        = 1'b0;
          req_ready_next = 1'b0;
          state_next     = SHIFT;
        end
      end

      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (!sck_reg) begin
            // End of low phase: raise sck and sample miso as it stood
            // before the rise. Only the data half (bits 32..63) is kept.
            sck_next = 1'b1;
            if (bit_cnt_reg[5]) begin
              rx_next = {rx_reg[30:0], miso};
            end
          end else begin
            // End of high phase: sck falls and the next bit is presented.
            sck_next     = 1'b0;
            tx_next      = {tx_reg[62:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 6'd1;
            if (bit_cnt_reg == 6'd63) begin
              ss_next         = 1'b1;
              resp_data_next  = rx_reg;
              resp_valid_next = 1'b1;
              state_next      = DONE;
            end
          end
        end else begin
          div_next = div_reg + DIV_ONE;
        end
      end

      DONE: begin
        // req_ready stays low here so a waiting request is only taken in
        // the IDLE cycle after the response handshake, which also keeps
        // ss high for at least two cycles between frames.
        if (resp_ready) begin
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          state_next      = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Testbench for spi_flash_reader: two instances (CLK_DIV=1 and CLK_DIV=3)
// share one behavioural flash slave. Only one instance is active at a time;
// the idle one holds sck=0, ss=1, mosi=0, so the bus lines are simply merged.
module tb_spi_flash_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic        resp_ready = 1'b1;
  logic        cur = 1'b0;   // 0 selects the CLK_DIV=1 instance, 1 the CLK_DIV=3 one
  logic        miso = 1'b0;

  logic        req_ready1, req_ready3, resp_valid1, resp_valid3;
  logic        sck1, sck3, ss1, ss3, mosi1, mosi3;
  logic [31:0] resp_data1, resp_data3;

  wire req_valid1 = req_valid & ~cur;
  wire req_valid3 = req_valid & cur;

  always #5 clock = ~clock;

  spi_flash_reader #(.CLK_DIV(1)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
    .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso)
  );

  spi_flash_reader #(.CLK_DIV(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr),
    .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_data(resp_data3),
    .sck(sck3), .ss(ss3), .mosi(mosi3), .miso(miso)
  );

  // Views of the currently selected instance.
  wire        c_ss         = cur ? ss3 : ss1;
  wire        c_sck        = cur ? sck3 : sck1;
  wire        c_mosi       = cur ? mosi3 : mosi1;
  wire        c_req_ready  = cur ? req_ready3 : req_ready1;
  wire        c_resp_valid = cur ? resp_valid3 : resp_valid1;
  wire [31:0] c_resp_data  = cur ? resp_data3 : resp_data1;

  // Merged SPI bus seen by the flash model.
  wire sck_s  = sck1 | sck3;
  wire ss_s   = ss1 & ss3;
  wire mosi_s = mosi1 | mosi3;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    case (a)
      24'h000004: return 32'hDEADBEEF;
      24'hABCDEF: return 32'h12345678;
      default:    return {a[7:0] ^ 8'hA5, a[15:8], a[23:16], 8'h3C};
    endcase
  endfunction

  function automatic logic pick(input logic [31:0] w, input int i);
    return w[i];
  endfunction

  // Flash model: captures mosi on sck rises, drives miso after sck falls.
  int          rises = 0;
  logic [63:0] cap = '0;
  logic [7:0]  cmd_seen = '0;
  logic [23:0] addr_seen = '0;
  logic [31:0] frame_word = '0;

  always @(posedge sck_s or negedge ss_s) begin
    if (sck_s) begin
      cap   <= {cap[62:0], mosi_s};
      rises <= rises + 1;
    end else begin
      cap   <= '0;
      rises <= 0;
    end
  end

  always @(negedge sck_s or negedge ss_s) begin
    if (!ss_s && rises == 32) begin
      cmd_seen   <= cap[31:24];
      addr_seen  <= cap[23:0];
      frame_word <= flash_word(cap[23:0]);
      miso       <= pick(flash_word(cap[23:0]), 31);
    end else if (!ss_s && rises > 32 && rises < 64) begin
      miso <= pick(frame_word, 63 - rises);
    end else begin
      miso <= 1'b0;
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  // Issue one request on the selected instance. Returns at the first
  // negedge after the accepting edge (cycle 1 of the frame).
  task automatic issue(input logic [23:0] addr);
    n_checks++;
    if (c_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%b required 1", c_req_ready);
    end
    req_addr  = addr;
    req_valid = 1'b1;
    exp_q.push_back(flash_word(addr));
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Observe a frame from cycle 1 until resp_valid and check it.
  task automatic collect(input int cd, input logic [23:0] addr, input string name);
    int          c;
    int          low_cnt;
    int          run;
    int          bad;
    logic        prev;
    bit          got;
    logic [31:0] e;
    low_cnt = 0; run = 0; bad = 0; prev = 1'b0; got = 0;
    for (c = 1; c <= 128 * cd + 20; c++) begin
      if (c > 1) @(negedge clock);
      if (c_resp_valid === 1'b1) begin
        got = 1;
        break;
      end
      if (c_ss === 1'b0) begin
        low_cnt++;
        if (c_sck === prev) run++;
        else begin
          if (run != cd) bad++;
          run  = 1;
          prev = c_sck;
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: no resp_valid within %0d cycles", name, 128 * cd + 20);
      return;
    end
    if (run != cd) bad++;
    n_checks++;
    if (c != 128 * cd + 1) begin
      n_fail++;
      $display("FAIL %s_latency: resp_valid at cycle %0d required %0d", name, c, 128 * cd + 1);
    end
    n_checks++;
    if (low_cnt != 128 * cd) begin
      n_fail++;
      $display("FAIL %s_ss_low: ss low %0d cycles required %0d", name, low_cnt, 128 * cd);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_sck_phase: %0d sck phases not %0d cycles long", name, bad, cd);
    end
    n_checks++;
    if (rises != 64) begin
      n_fail++;
      $display("FAIL %s_rises: %0d sck rises required 64", name, rises);
    end
    n_checks++;
    if (cmd_seen !== 8'h03 || addr_seen !== addr) begin
      n_fail++;
      $display("FAIL %s_mosi: cmd=%h addr=%h required 03 %h", name, cmd_seen, addr_seen, addr);
    end
    n_checks++;
    if (c_ss !== 1'b1 || c_sck !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_bus: ss=%b sck=%b required 1 0", name, c_ss, c_sck);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: response %h with nothing expected", name, c_resp_data);
    end else begin
      e = exp_q.pop_front();
      if (c_resp_data !== e) begin
        n_fail++;
        $display("FAIL %s_data: resp_data=%h required %h", name, c_resp_data, e);
      end
    end
    $display("%s: addr=%h data=%h latency=%0d ss_low=%0d", name, addr, c_resp_data, c, low_cnt);
    if (resp_ready) begin
      @(negedge clock);
      n_checks++;
      if (c_resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_one_cycle: resp_valid=%b required 0", name, c_resp_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if ({ss1, sck1, mosi1, req_ready1, resp_valid1} !== 5'b10010 || resp_data1 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_idle1: ss,sck,mosi,rdy,rv=%b data=%h required 10010 0",
                 {ss1, sck1, mosi1, req_ready1, resp_valid1}, resp_data1);
      end
      n_checks++;
      if ({ss3, sck3, mosi3, req_ready3, resp_valid3} !== 5'b10010 || resp_data3 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_idle3: ss,sck,mosi,rdy,rv=%b data=%h required 10010 0",
                 {ss3, sck3, mosi3, req_ready3, resp_valid3}, resp_data3);
      end
    end
    $display("reset: idle state checked for 10 cycles, mosi=%b", c_mosi);
  endtask

  task automatic test_div1();
    cur = 1'b0;
    resp_ready = 1'b1;
    issue(24'h000004);
    collect(1, 24'h000004, "div1");
  endtask

  task automatic test_div3();
    cur = 1'b1;
    resp_ready = 1'b1;
    @(negedge clock);
    issue(24'hABCDEF);
    collect(3, 24'hABCDEF, "div3");
    @(negedge clock);
    cur = 1'b0;
  endtask

  task automatic test_hold();
    cur = 1'b0;
    resp_ready = 1'b0;
    @(negedge clock);
    issue(24'h000020);
    collect(1, 24'h000020, "hold_a");
    req_addr  = 24'h000040;
    req_valid = 1'b1;
    exp_q.push_back(flash_word(24'h000040));
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_checks++;
      if (c_resp_valid !== 1'b1 || c_resp_data !== flash_word(24'h000020) ||
          c_req_ready !== 1'b0 || c_ss !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stable: rv=%b data=%h rdy=%b ss=%b required 1 %h 0 1",
                 c_resp_valid, c_resp_data, c_req_ready, c_ss, flash_word(24'h000020));
      end
    end
    resp_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (c_resp_valid !== 1'b0 || c_req_ready !== 1'b1 || c_ss !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: rv=%b rdy=%b ss=%b required 0 1 1", c_resp_valid, c_req_ready, c_ss);
    end
    @(negedge clock);
    req_valid = 1'b0;
    n_checks++;
    if (c_ss !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_restart: ss=%b required 0", c_ss);
    end
    collect(1, 24'h000040, "hold_b");
  endtask

  task automatic test_reset_mid();
    cur = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    req_addr  = 24'h000010;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (80) @(negedge clock);   // cycle 81: first cycle of bit 40
    n_checks++;
    if (c_ss !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_active: ss=%b required 0 before reset", c_ss);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (c_ss !== 1'b1 || c_sck !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: ss=%b sck=%b required 1 0", c_ss, c_sck);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_checks++;
      if (c_resp_valid !== 1'b0 || c_ss !== 1'b1 || c_req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midreset_idle: rv=%b ss=%b rdy=%b required 0 1 1", c_resp_valid, c_ss, c_req_ready);
      end
    end
    $display("midreset: frame abandoned at bit 40");
    issue(24'h000004);
    collect(1, 24'h000004, "after_reset");
  endtask

  task automatic test_back_to_back();
    int gap;
    cur = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    req_addr  = 24'h000000;
    req_valid = 1'b1;
    exp_q.push_back(flash_word(24'h000000));
    @(negedge clock);
    req_addr = 24'h000100;
    exp_q.push_back(flash_word(24'h000100));
    collect(1, 24'h000000, "b2b_a");
    gap = 1;   // the DONE cycle, already checked with ss high
    while (c_ss === 1'b1 && gap < 12) begin
      gap++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    n_checks++;
    if (gap < 2 || c_ss !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: ss high %0d cycles, ss=%b, required >=2 then 0", gap, c_ss);
    end
    $display("b2b: ss high gap %0d cycles", gap);
    collect(1, 24'h000100, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div3();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d responses missing, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- SPI master that turns a single-word read request from the bus side into a serial-flash `03h` READ frame on sck/ss/mosi, and collects the 32-bit reply on miso.
- Sits directly upstream of the flash device model: drives its sck, ss and mosi, and consumes its miso.
- Runs entirely on the system clock; sck is generated internally by a divider.

Parameters:
- CLK_DIV, 1: system-clock cycles per sck half-period. Must be ≥1; elaboration-time assertion fails on 0.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  read request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  24  flash byte address, sent MSB first
- resp_valid  output  1  read data valid
- resp_ready  input  1  response consumed when resp_valid && resp_ready
- resp_data  output  32  word received; first miso bit lands in [31]
- sck  output  1  SPI clock, mode 0 (idles low)
- ss  output  1  SPI chip select, active-low
- mosi  output  1  SPI data to flash
- miso  input  1  SPI data from flash

Behaviour:
- Reset values (asynchronous): state=IDLE, ss=1, sck=0, mosi=0, req_ready=1, resp_valid=0, resp_data=0, bit counter=0, divider=0.
- Reset mid-frame: ss rises immediately and the frame is abandoned. No response is produced; the block returns to IDLE.
- States:
  - IDLE: req_ready=1; ss=1, sck=0, mosi=0. On handshake, load the 64-bit TX shift register {8'h03, req_addr, 32'h0}, set counter=0, go to SHIFT.
  - SHIFT: ss=0, req_ready=0.
    - Each bit is CLK_DIV cycles with sck=0 followed by CLK_DIV cycles with sck=1.
    - mosi = TX[63] throughout the bit. TX shifts left by one (zero-fill) on the clock edge that ends the high phase, i.e. at the sck fall.
    - miso is sampled on the clock edge that raises sck, using the value present before the rise. For bits 32..63 (data phase) it is shifted into RX[0]; bits 0..31 are ignored.
    - Counter increments at the end of each high phase. After bit 63's high phase: sck=0, ss=1, resp_data=RX, go to DONE.
  - DONE: resp_valid=1, ss=1, req_ready=0. resp_data is held stable until resp_ready; on handshake, resp_valid=0 and go to IDLE.
- Frame length: 64 sck periods = 128*CLK_DIV cycles with ss low.
- Latency: request accepted at edge T. ss is low from T+1 through T+128*CLK_DIV. resp_valid first high at T+128*CLK_DIV+1.
- ss-high gap: ss is high for ≥2 consecutive cycles between frames (DONE ≥1 cycle plus IDLE ≥1 cycle), guaranteeing the flash resets its frame state.
- Back-to-back requests: req_valid held high while in DONE is not accepted until the IDLE cycle after resp handshake.
- resp_ready high at DONE entry: resp_valid is visible for exactly 1 cycle.
- No bursts, no write/erase commands; the command byte is always 03h.
- Address handling: bits are sent as given; no alignment check. Byte ordering of resp_data is raw serial order, MSB-first, with no swap.
- Outputs are registered (glitch-free sck/ss).

Test Plan:
- Reset, then idle 10 cycles -> ss=1, sck=0, mosi=0, req_ready=1, resp_valid=0 throughout.
- CLK_DIV=1, req_addr=24'h000004, flash word 32'hDEADBEEF:
  - mosi bits captured on sck rises = 03h, then 000004h.
  - 64 sck rising edges counted.
  - resp_valid at T+129 with resp_data=32'hDEADBEEF.
- CLK_DIV=3, req_addr=24'hABCDEF, miso fed 32'h12345678 by bench slave:
  - sck high and low phases each 3 cycles.
  - ss low for 384 cycles.
  - resp_data=32'h12345678.
- Hold resp_ready=0 for 20 cycles after resp_valid with req_valid=1 -> resp_data stable, req_ready=0, no new frame (ss stays high). Raise resp_ready -> next frame starts with ss low two cycles later.
- Assert reset at bit 40 of a frame -> ss=1 in the same cycle (asynchronous). After release, no resp_valid; a new request completes normally with correct data.
- Two back-to-back requests (addr 0x000000 then 0x000100) with resp_ready=1 -> two separate frames, ss high ≥2 cycles between them, correct word for each.
